axi_xbar_aw_sched: RTL and testbench



---
 rtl/axi_xbar_pkg.sv | 12 +
 rtl/axi_xbar_idx_fifo.sv | 65 ++++++
 rtl/axi_xbar_aw_sched.sv | 124 ++++++++++++
 tb/tb_axi_xbar_aw_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared definitions for the AXI crossbar: select-width helper and default
// depth of the per-output AW->W index FIFO.
package axi_xbar_pkg;

   localparam int FIFO_DEPTH_DEFAULT = 4;

   // A single source still needs a 1-bit select so downstream muxes keep a port.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axi_xbar_idx_fifo.sv
// Synchronous FIFO of source indices recording AW grant order; the head
// steers W beats until WLAST pops it.
module axi_xbar_idx_fifo
   import axi_xbar_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_idx,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Report index 0 while empty so W select is deterministic after reset.
   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_xbar_aw_sched.sv
// Write-address scheduler for one crossbar output: locking round-robin AW
// arbitration, source-tagged IDs, and in-order W steering from a grant FIFO.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; valid never depends on ready, and a raised valid (with its payload)
// holds until the transfer.
module axi_xbar_aw_sched
   import axi_xbar_pkg::*;
#(
   parameter int NB_REQ     = 4,
   parameter int ID_WIDTH   = 4,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   localparam int SEL_W     = sel_width(NB_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NB_REQ-1:0]            req_aw_valid_i,
   output logic [NB_REQ-1:0]            req_aw_ready_o,
   input  logic [NB_REQ*ID_WIDTH-1:0]   req_aw_id_i,
   output logic                         aw_valid_o,
   input  logic                         aw_ready_i,
   output logic [ID_WIDTH+SEL_W-1:0]    aw_id_o,
   output logic [SEL_W-1:0]             aw_sel_o,
   input  logic [NB_REQ-1:0]            req_w_valid_i,
   input  logic [NB_REQ-1:0]            req_w_last_i,
   output logic [NB_REQ-1:0]            req_w_ready_o,
   output logic                         w_valid_o,
   output logic                         w_last_o,
   input  logic                         w_ready_i,
   output logic [SEL_W-1:0]             w_sel_o
);

   localparam logic [SEL_W:0]   NB_REQ_EXT = (SEL_W + 1)'(NB_REQ);
   localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NB_REQ - 1);

   logic [SEL_W-1:0]    rr_q;
   logic                lock_q;
   logic [SEL_W-1:0]    lock_idx_q;

   logic [2*NB_REQ-1:0] req_dbl;
   logic [2*NB_REQ-1:0] req_shift;
   logic [NB_REQ-1:0]   req_rot;
   logic [SEL_W-1:0]    rot_off;
   logic [SEL_W:0]      idx_sum;
   logic [SEL_W-1:0]    arb_idx;
   logic [SEL_W-1:0]    winner;
   logic                cand_valid;
   logic                aw_hs;

   logic                fifo_full;
   logic                fifo_empty;
   logic [SEL_W-1:0]    fifo_head;
   logic                w_pop;

   logic [ID_WIDTH-1:0] id_arr [NB_REQ];

   for (genvar g = 0; g < NB_REQ; g++) begin : g_id
      assign id_arr[g] = req_aw_id_i[g*ID_WIDTH +: ID_WIDTH];
   end

   // Rotate requests so rr_q sits at bit 0, pick the lowest set bit, then
   // rotate the offset back into a source index.
   assign req_dbl   = {req_aw_valid_i, req_aw_valid_i};
   assign req_shift = req_dbl >> rr_q;
   assign req_rot   = req_shift[NB_REQ-1:0];

   always_comb begin
      rot_off = '0;
      for (int i = NB_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            rot_off = SEL_W'(i);
         end
      end
   end

   assign idx_sum = {1'b0, rr_q} + {1'b0, rot_off};
   assign arb_idx = (idx_sum >= NB_REQ_EXT) ? SEL_W'(idx_sum - NB_REQ_EXT)
                                            : idx_sum[SEL_W-1:0];

   // A stalled grant is frozen so the offered AW stays stable until accepted.
   assign winner     = lock_q ? lock_idx_q : arb_idx;
   assign cand_valid = lock_q ? req_aw_valid_i[lock_idx_q] : (|req_aw_valid_i);

   assign aw_valid_o     = cand_valid & ~fifo_full;
   assign aw_hs          = aw_valid_o & aw_ready_i;
   assign aw_sel_o       = winner;
   assign aw_id_o        = {winner, id_arr[winner]};
   assign req_aw_ready_o = aw_hs ? (NB_REQ'(1) << winner) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (aw_hs) begin
         rr_q   <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
         lock_q <= 1'b0;
      end else if (aw_valid_o) begin
         lock_q     <= 1'b1;
         lock_idx_q <= winner;
      end
   end

   axi_xbar_idx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SEL_W)
   ) u_idx_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (aw_hs),
      .push_idx (winner),
      .pop      (w_pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

   assign w_sel_o       = fifo_head;
   assign w_valid_o     = ~fifo_empty & req_w_valid_i[fifo_head];
   assign w_last_o      = req_w_last_i[fifo_head];
   assign req_w_ready_o = (~fifo_empty & w_ready_i) ? (NB_REQ'(1) << fifo_head) : '0;
   assign w_pop         = w_valid_o & w_ready_i & w_last_o;

endmodule

// File: tb/tb_axi_xbar_aw_sched.sv
// Directed and randomized bench for axi_xbar_aw_sched, checked against a
// queue-based model of grant order and round-robin rules.
module tb_axi_xbar_aw_sched;

   localparam int N   = 4;
   localparam int IDW = 4;
   localparam int SW  = 2;
   localparam int D   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic [N-1:0]       awv;
   logic [N-1:0]       aw_rdy_o;
   logic [N*IDW-1:0]   awid;
   logic               aw_valid_o;
   logic               awr;
   logic [IDW+SW-1:0]  aw_id_o;
   logic [SW-1:0]      aw_sel_o;
   logic [N-1:0]       wv;
   logic [N-1:0]       wl;
   logic [N-1:0]       w_rdy_o;
   logic               w_valid_o;
   logic               w_last_o;
   logic               wr;
   logic [SW-1:0]      w_sel_o;

   axi_xbar_aw_sched #(.NB_REQ(N), .ID_WIDTH(IDW), .FIFO_DEPTH(D)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_aw_valid_i (awv),
      .req_aw_ready_o (aw_rdy_o),
      .req_aw_id_i    (awid),
      .aw_valid_o     (aw_valid_o),
      .aw_ready_i     (awr),
      .aw_id_o        (aw_id_o),
      .aw_sel_o       (aw_sel_o),
      .req_w_valid_i  (wv),
      .req_w_last_i   (wl),
      .req_w_ready_o  (w_rdy_o),
      .w_valid_o      (w_valid_o),
      .w_last_o       (w_last_o),
      .w_ready_i      (wr),
      .w_sel_o        (w_sel_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: pending W sources in grant order, pointer, held grant.
   logic [SW-1:0] exp_q[$];
   int   m_rr   = 0;
   int   m_lock = -1;
   int   m_cand = 0;
   logic m_hs   = 1'b0;
   logic m_awv  = 1'b0;
   logic m_pop  = 1'b0;

   function automatic logic bit4(input logic [N-1:0] v, input int k);
      logic [N-1:0] t;
      t = v >> k;
      return t[0];
   endfunction

   function automatic logic [IDW-1:0] id_of(input int k);
      logic [N*IDW-1:0] t;
      t = awid >> (IDW * k);
      return t[IDW-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic observe();
      int   cand;
      int   head;
      logic cv;
      logic full;
      logic empty;
      logic exp_wv;
      logic [SW-1:0] c2;
      #1;
      full  = (exp_q.size() == D);
      empty = (exp_q.size() == 0);
      cv    = 1'b0;
      cand  = m_rr;
      if (m_lock >= 0) begin
         cand = m_lock;
         cv   = bit4(awv, m_lock);
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!cv && bit4(awv, (m_rr + i) % N)) begin
               cv   = 1'b1;
               cand = (m_rr + i) % N;
            end
         end
      end
      m_cand = cand;
      m_awv  = cv && !full;
      m_hs   = m_awv && awr;
      head   = empty ? 0 : int'(exp_q[0]);
      exp_wv = !empty && bit4(wv, head);
      m_pop  = exp_wv && wr && bit4(wl, head);
      c2     = SW'(cand);
      if (rst_n) begin
         chk("aw_valid", 32'(aw_valid_o), 32'(m_awv));
         if (cv) begin
            chk("aw_sel", 32'(aw_sel_o), 32'(cand));
            chk("aw_id", 32'(aw_id_o), 32'({c2, id_of(cand)}));
         end
         chk("aw_ready", 32'(aw_rdy_o), m_hs ? 32'(1 << cand) : 32'd0);
         chk("w_valid", 32'(w_valid_o), 32'(exp_wv));
         chk("w_ready", 32'(w_rdy_o), (!empty && wr) ? 32'(1 << head) : 32'd0);
         chk("w_sel", 32'(w_sel_o), 32'(head));
         if (!empty) chk("w_last", 32'(w_last_o), 32'(bit4(wl, head)));
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (!rst_n) begin
         exp_q.delete();
         m_rr   = 0;
         m_lock = -1;
      end else begin
         if (m_pop) void'(exp_q.pop_front());
         if (m_hs) begin
            exp_q.push_back(SW'(m_cand));
            m_rr   = (m_cand + 1) % N;
            m_lock = -1;
         end else if (m_awv) begin
            m_lock = m_cand;
         end
      end
      #1;
   endtask

   task automatic drain();
      awv = '0; wv = '1; wl = '1; wr = 1'b1;
      for (int k = 0; k < 2 * D && exp_q.size() != 0; k++) begin
         observe();
         advance();
      end
      wv = '0; wl = '0; wr = 1'b0;
   endtask

   logic [N-1:0] pend;
   int cnt0, cnt3;
   logic hs0, hs3;

   initial begin
      rst_n = 1'b0; awv = '0; awid = '0; awr = 1'b0; wv = '0; wl = '0; wr = 1'b0;
      repeat (2) begin observe(); advance(); end
      rst_n = 1'b1;

      // Reset state
      observe();
      chk("rst_aw_valid", 32'(aw_valid_o), 32'd0);
      chk("rst_aw_ready", 32'(aw_rdy_o), 32'd0);
      chk("rst_w_valid", 32'(w_valid_o), 32'd0);
      chk("rst_w_ready", 32'(w_rdy_o), 32'd0);
      chk("rst_w_sel", 32'(w_sel_o), 32'd0);
      chk("rst_aw_sel", 32'(aw_sel_o), 32'd0);
      advance();

      // Fairness with W draining each accepted burst in the next cycle
      awid = 16'hC5A3; awv = 4'hF; awr = 1'b1; wv = 4'hF; wl = 4'hF; wr = 1'b1;
      for (int k = 0; k < 5; k++) begin
         observe();
         chk("fair_sel", 32'(aw_sel_o), 32'(k % 4));
         chk("fair_idtag", 32'(aw_id_o[IDW +: 2]), 32'(k % 4));
         advance();
      end
      drain();

      // Lock: source 2 stalled, source 1 joins on the second cycle
      awv = 4'b0100; awr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 1) awv = 4'b0110;
         observe();
         chk("lock_sel", 32'(aw_sel_o), 32'd2);
         advance();
      end
      awr = 1'b1;
      observe();
      chk("lock_acc2", 32'(aw_rdy_o), 32'b0100);
      advance();
      awv = 4'b0010;
      observe();
      chk("lock_acc1", 32'(aw_rdy_o), 32'b0010);
      advance();
      drain();

      // W ordering: grants 3 then 0, both bursts offered concurrently
      awr = 1'b1;
      awv = 4'b1000; observe(); advance();
      awv = 4'b0001; observe(); advance();
      awv = '0; wv = 4'b1001; wr = 1'b1; cnt0 = 0; cnt3 = 0;
      for (int k = 0; k < 8; k++) begin
         wl = {cnt3 == 3, 2'b00, cnt0 == 3};
         observe();
         chk("word_sel", 32'(w_sel_o), (k < 4) ? 32'd3 : 32'd0);
         if (k < 4) chk("word_rdy0", 32'(w_rdy_o[0]), 32'd0);
         hs0 = w_rdy_o[0] && wv[0];
         hs3 = w_rdy_o[3] && wv[3];
         advance();
         if (hs0) cnt0++;
         if (hs3) cnt3++;
         if (cnt0 == 4) wv[0] = 1'b0;
         if (cnt3 == 4) wv[3] = 1'b0;
      end
      chk("word_beats", 32'(cnt0 * 16 + cnt3), 32'h44);
      drain();

      // Full: four AWs with W stalled, then one WLAST frees a slot
      awv = 4'hF; awr = 1'b1; wv = '0; wr = 1'b0;
      repeat (4) begin observe(); advance(); end
      observe();
      chk("full_block", 32'(aw_valid_o), 32'd0);
      advance();
      wv = 4'hF; wl = 4'hF; wr = 1'b1;
      observe();
      chk("full_no_bypass", 32'(aw_valid_o), 32'd0);
      chk("full_pop_w", 32'(w_valid_o), 32'd1);
      advance();
      wv = '0; wr = 1'b0;
      observe();
      chk("full_after_pop", 32'(aw_valid_o), 32'd1);
      advance();
      drain();

      // Early W from source 1 before its AW
      awv = '0; wv = 4'b0010; wl = 4'b0010; wr = 1'b1; awr = 1'b1;
      repeat (2) begin
         observe();
         chk("early_w_valid", 32'(w_valid_o), 32'd0);
         advance();
      end
      awv = 4'b0010;
      observe();
      chk("early_aw_acc", 32'(aw_rdy_o), 32'b0010);
      chk("early_no_bypass", 32'(w_valid_o), 32'd0);
      advance();
      awv = '0;
      observe();
      chk("early_w_next", 32'(w_rdy_o), 32'b0010);
      advance();
      drain();

      // Reset with two bursts queued
      awr = 1'b1;
      awv = 4'b0001; observe(); advance();
      awv = 4'b0100; observe(); advance();
      awv = '0; rst_n = 1'b0; wv = 4'hF; wl = 4'hF; wr = 1'b1;
      observe(); advance();
      rst_n = 1'b1; awv = 4'b1001;
      observe();
      chk("rstmid_w_valid", 32'(w_valid_o), 32'd0);
      chk("rstmid_sel0", 32'(aw_sel_o), 32'd0);
      advance();
      awv = 4'b1000;
      observe();
      chk("rstmid_sel3", 32'(aw_sel_o), 32'd3);
      advance();
      drain();

      // Randomized traffic with sticky AW requests
      pend = '0;
      for (int c = 0; c < 600; c++) begin
         rst_n = (c != 300);
         for (int i = 0; i < N; i++) begin
            if (!bit4(pend, i) && $urandom_range(0, 2) == 0) begin
               pend = pend | (N'(1) << i);
               awid = (awid & ~((N*IDW)'(4'hF) << (IDW * i))) |
                      ((N*IDW)'($urandom_range(0, 15)) << (IDW * i));
            end
         end
         awv = pend;
         awr = ($urandom_range(0, 9) < 7);
         wv  = N'($urandom_range(0, 15));
         wl  = N'($urandom_range(0, 15));
         wr  = ($urandom_range(0, 9) < 7);
         observe();
         pend = pend & ~aw_rdy_o;
         if (!rst_n) pend = '0;
         advance();
      end
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
